// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - FSM state codes for the scheduler sequencer
//   - parity codes driven on tx_check (none / odd / even)
//   - baud word width and the default baud value used out of reset
//   - wrap_inc(): round-robin pointer advance modulo the requester count
package uart_tx_scheduler_pkg;

  localparam int BAUD_W = 20;
  localparam logic [BAUD_W-1:0] DEF_BAUD_RATE = 20'd115200;

  localparam logic [1:0] CHK_NONE = 2'd0;
  localparam logic [1:0] CHK_ODD  = 2'd1;
  localparam logic [1:0] CHK_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  // Next requester index after g, wrapping n-1 -> 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] g, input int n);
    if (int'(g) >= n - 1) return 3'd0;
    else return g + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick.
// Returns the first asserted request at or after rr_ptr_i, wrapping
// NREQ-1 -> 0, both as a one-hot vector and as an index.
// Ports:
//   req_valid_i  in  NREQ  request lines
//   rr_ptr_i     in  3     highest-priority index (must be < NREQ)
//   grant_oh_o   out NREQ  one-hot winner (all zero when no request)
//   grant_idx_o  out 3     winner index (0 when no request)
//   grant_any_o  out 1     at least one request present
module uart_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [2:0]      rr_ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [2:0]      grant_idx_o,
  output logic            grant_any_o
);

  // cand[k] is the requester that has priority rank k this cycle.
  logic [2:0] cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = (int'(rr_ptr_i) + gi >= NREQ) ? 3'(int'(rr_ptr_i) + gi - NREQ)
                                                    : 3'(int'(rr_ptr_i) + gi);
  end

  // Walk ranks from lowest priority to highest so the last hit wins.
  always_comb begin
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (cand[k] == 3'(j) && req_valid_i[j]) begin
          grant_idx_o = cand[k];
          grant_any_o = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
    assign grant_oh_o[gi] = grant_any_o && (grant_idx_o == 3'(gi));
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NREQ byte
// requesters. Ownership is granted round-robin and held for a whole packet
// (until the byte flagged last). Baud and parity are latched at grant time
// and stay fixed for the packet.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   req_valid/data/last   per-requester byte offer (data at [8i+:8])
//   req_ready             one-cycle accept strobe to the owner
//   cfg_baud, cfg_check   configuration sampled at each packet grant
//   tx_en, tx_dat         byte handed to the transmitter (stable while tx_en)
//   tx_check, tx_baud     transmitter frame check / baud settings
//   tx_done               transmitter per-byte completion pulse
//   busy, grant_id        grant held / current-or-last owner
//   timeout_err           sticky abandon flag
// Build option: TX_TIMEOUT_EN adds a stall counter (TMO_CYC cycles in SEND
// or HOLD abandons the packet and sets timeout_err). Without it the
// scheduler waits indefinitely and timeout_err is constant 0.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int                NREQ      = 4,
  parameter logic [BAUD_W-1:0] DEF_BAUD  = DEF_BAUD_RATE,
  parameter logic [1:0]        DEF_CHECK = CHK_NONE,
  parameter int                TMO_CYC   = 2000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  input  logic [BAUD_W-1:0]   cfg_baud,
  input  logic [1:0]          cfg_check,
  output logic                tx_en,
  output logic [7:0]          tx_dat,
  output logic [1:0]          tx_check,
  output logic [BAUD_W-1:0]   tx_baud,
  input  logic                tx_done,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                timeout_err
);

  state_e            state_q, state_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_dat_q, tx_dat_d;
  logic              last_q, last_d;
  logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
  logic [1:0]        tx_check_q, tx_check_d;

  logic [NREQ-1:0]   arb_oh_unused;
  logic [2:0]        arb_idx;
  logic              arb_any;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_o  (arb_oh_unused),
    .grant_idx_o (arb_idx),
    .grant_any_o (arb_any)
  );

  // Owner's request lines, selected by the locked grant.
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_hit;
  assign tmo_hit = (state_q == ST_SEND || state_q == ST_HOLD) &&
                   (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    tx_en_d    = tx_en_q;
    tx_dat_d   = tx_dat_q;
    last_d     = last_q;
    tx_baud_d  = tx_baud_q;
    tx_check_d = tx_check_q;
`ifdef TX_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d    = arb_idx;
          tx_baud_d  = cfg_baud;
          tx_check_d = cfg_check;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Byte is taken even if the owner dropped valid here.
        tx_dat_d = sel_data;
        last_d   = sel_last;
        tx_en_d  = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) begin
          tx_en_d = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // One idle cycle with tx_en low lets the transmitter re-arm.
        if (last_q) begin
          rr_ptr_d = wrap_inc(grant_q, NREQ);
          state_d  = ST_IDLE;
        end else if (sel_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (sel_valid) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef TX_TIMEOUT_EN
    // Only abandon while still stuck; a same-cycle tx_done wins.
    if (tmo_hit && state_d == state_q) begin
      tx_en_d       = 1'b0;
      timeout_err_d = 1'b1;
      rr_ptr_d      = wrap_inc(grant_q, NREQ);
      state_d       = ST_IDLE;
    end
    if ((state_d == state_q) && (state_q == ST_SEND || state_q == ST_HOLD))
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_dat_q   <= '0;
      last_q     <= 1'b0;
      tx_baud_q  <= DEF_BAUD;
      tx_check_q <= DEF_CHECK;
`ifdef TX_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tx_en_q    <= tx_en_d;
      tx_dat_q   <= tx_dat_d;
      last_q     <= last_d;
      tx_baud_q  <= tx_baud_d;
      tx_check_q <= tx_check_d;
`ifdef TX_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_LOAD) && (grant_q == 3'(gi));
  end

  assign tx_en    = tx_en_q;
  assign tx_dat   = tx_dat_q;
  assign tx_baud  = tx_baud_q;
  assign tx_check = tx_check_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

`ifdef TX_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  // TMO_CYC only matters when the stall counter is built in.
  logic tmo_unused;
  assign tmo_unused  = (TMO_CYC > 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler (NREQ=4, TMO_CYC=100).
// Directed sequences, a table of single-byte grants, and a randomized run
// against a packet-level round-robin model. The timeout sequence is
// compiled only when TX_TIMEOUT_EN is defined.
module tb_uart_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int FRAME = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic [19:0]       cfg_baud = 20'd115200;
  logic [1:0]        cfg_check = 2'd0;
  logic              tx_en;
  logic [7:0]        tx_dat;
  logic [1:0]        tx_check;
  logic [19:0]       tx_baud;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [2:0]        grant_id;
  logic              timeout_err;

  uart_tx_scheduler #(.NREQ(NREQ), .TMO_CYC(100)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cfg_baud(cfg_baud),
    .cfg_check(cfg_check), .tx_en(tx_en), .tx_dat(tx_dat), .tx_check(tx_check),
    .tx_baud(tx_baud), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Requester queues: {last, data}. Fronts are offered while use_q is set.
  logic [8:0] rq [NREQ][$];
  logic [8:0] mq [NREQ][$];
  bit         use_q = 1'b1;
  bit         tx_auto = 1'b0;
  int         frame_cnt = 0;
  int         pop_idx = -1;
  logic [NREQ-1:0] ready_seen = '0;

  typedef struct { int g; logic [7:0] d; bit first; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] mask; logic [7:0] dat; logic [19:0] baud; logic [1:0] chk; int exp_g;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    logic [8:0] f;
    if (use_q) begin
      for (int i = 0; i < NREQ; i++) begin
        f = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
        req_valid[i]       = rq[i].size() > 0;
        req_data[8*i +: 8] = f[7:0];
        req_last[i]        = f[8];
      end
    end
    if (tx_auto) tx_done = tx_en && (frame_cnt == FRAME - 1);
    @(posedge CLK); #1;
    if (tx_auto) frame_cnt = tx_en ? frame_cnt + 1 : 0;
    if (use_q && pop_idx >= 0) begin
      if (rq[pop_idx].size() > 0) void'(rq[pop_idx].pop_front());
      pop_idx = -1;
    end
    ready_seen |= req_ready;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) pop_idx = i;
  endtask

  task automatic reset_dut();
    RST = 1'b1; tx_done = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    pop_idx = -1;
    step(); step();
    RST = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_tx_dat"}, tx_dat, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_baud"}, tx_baud, 20'd115200);
    chk({tag, "_check"}, tx_check, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  // Wait for the next byte, verify it, hold it two cycles, then complete it.
  task automatic serve(input int g, input logic [7:0] d, input logic [19:0] b, input logic [1:0] c);
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 40) begin step(); n++; end
    chk("serve_start", tx_en, 1);
    if (tx_en === 1'b1) begin
      $display("tx byte: grant=%0d data=%02h baud=%0d check=%0d", grant_id, tx_dat, tx_baud, tx_check);
      chk("serve_grant", grant_id, g);
      chk("serve_dat", tx_dat, d);
      chk("serve_baud", tx_baud, b);
      chk("serve_check", tx_check, c);
      repeat (2) begin step(); chk("serve_hold", {tx_en, tx_dat}, {1'b1, d}); end
      tx_done = 1'b1; step(); tx_done = 1'b0;
      chk("serve_drop", tx_en, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, ptr, found, guard;
    bit first, prev_en, prev_busy;
    logic [8:0] w;
    logic [19:0] pkt_baud;
    logic [3:0] oh;

    vt[0] = '{4'b1111, 8'h10, 20'd9600,   2'd1, 0};
    vt[1] = '{4'b1111, 8'h21, 20'd19200,  2'd2, 1};
    vt[2] = '{4'b1111, 8'h32, 20'd38400,  2'd0, 2};
    vt[3] = '{4'b1111, 8'h43, 20'd57600,  2'd1, 3};
    vt[4] = '{4'b1111, 8'h54, 20'd115200, 2'd2, 0};
    vt[5] = '{4'b0101, 8'h65, 20'd4800,   2'd0, 2};
    vt[6] = '{4'b0011, 8'h76, 20'd2400,   2'd1, 0};
    vt[7] = '{4'b1000, 8'h87, 20'd1200,   2'd2, 3};
    vt[8] = '{4'b0110, 8'h98, 20'd300,    2'd0, 1};
    vt[9] = '{4'b0001, 8'hA9, 20'd921600, 2'd1, 0};

    // Reset values; cfg differs from default so a leak would show.
    cfg_baud = 20'd1234; cfg_check = 2'd2;
    reset_dut();
    chk_reset_vals("rst");
    cfg_baud = 20'd115200; cfg_check = 2'd0;

    // Single byte: ready at t+1, tx_en at t+2, then back to idle, ptr -> 1.
    rq[0].push_back(9'h1A5);
    step();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_en_early", tx_en, 0);
    step();
    chk("t1_tx_en", tx_en, 1);
    chk("t1_tx_dat", tx_dat, 8'hA5);
    chk("t1_ready_off", req_ready, 0);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    chk("t1_gap_busy", busy, 1);
    step();
    chk("t1_idle", busy, 0);
    rq[0].push_back(9'h13C); rq[1].push_back(9'h14D);
    serve(1, 8'h4D, 20'd115200, 2'd0);
    serve(0, 8'h3C, 20'd115200, 2'd0);

    // Lock: req1 waits for req0's whole packet.
    reset_dut();
    rq[0].push_back(9'h011); rq[0].push_back(9'h022); rq[0].push_back(9'h133);
    rq[1].push_back(9'h177);
    ready_seen = '0;
    serve(0, 8'h11, 20'd115200, 2'd0);
    serve(0, 8'h22, 20'd115200, 2'd0);
    serve(0, 8'h33, 20'd115200, 2'd0);
    chk("lock_blocked", ready_seen[1], 0);
    serve(1, 8'h77, 20'd115200, 2'd0);

    // Config per packet: change mid-packet has no effect until next grant.
    cfg_baud = 20'd9600; cfg_check = 2'd1;
    rq[2].push_back(9'h0AA); rq[2].push_back(9'h1BB);
    serve(2, 8'hAA, 20'd9600, 2'd1);
    cfg_baud = 20'd115200; cfg_check = 2'd2;
    serve(2, 8'hBB, 20'd9600, 2'd1);
    rq[3].push_back(9'h1CC);
    serve(3, 8'hCC, 20'd115200, 2'd2);

    // HOLD: req2 pauses mid-packet, req3 starves; stray tx_done ignored.
    rq[2].push_back(9'h001); rq[3].push_back(9'h102);
    serve(2, 8'h01, 20'd115200, 2'd2);
    ready_seen = '0;
    for (int k = 0; k < 10; k++) begin
      tx_done = (k == 5);
      step();
      chk("hold_state", {busy, tx_en, grant_id}, {1'b1, 1'b0, 3'd2});
    end
    tx_done = 1'b0;
    chk("hold_starve", ready_seen, 0);
    rq[2].push_back(9'h103);
    serve(2, 8'h03, 20'd115200, 2'd2);
    serve(3, 8'h02, 20'd115200, 2'd2);

    // Table of single-byte grants from a fresh pointer.
    reset_dut();
    use_q = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_valid = vt[k].mask; req_data = {4{vt[k].dat}}; req_last = '1;
      cfg_baud = vt[k].baud; cfg_check = vt[k].chk;
      oh = 4'b0001 << vt[k].exp_g;
      step();
      $display("table row %0d: mask=%b grant=%0d ready=%b", k, vt[k].mask, grant_id, req_ready);
      chk("tbl_ready", req_ready, oh);
      chk("tbl_grant", grant_id, vt[k].exp_g);
      chk("tbl_baud", tx_baud, vt[k].baud);
      chk("tbl_check", tx_check, vt[k].chk);
      step();
      chk("tbl_tx", {tx_en, tx_dat}, {1'b1, vt[k].dat});
      req_valid = '0; cfg_baud = ~vt[k].baud;
      step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      step();
      chk("tbl_idle", busy, 0);
    end
    use_q = 1'b1;

    // Randomized packets against a round-robin packet model.
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      int np, len;
      np = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
      end
      mq[i] = rq[i];
    end
    ptr = 0;
    for (guard = 0; guard < 64; guard++) begin
      found = -1;
      for (int k = 0; k < NREQ; k++)
        if (found < 0 && mq[(ptr + k) % NREQ].size() > 0) found = (ptr + k) % NREQ;
      if (found < 0) break;
      first = 1'b1;
      w = 9'h000;
      while (!w[8] && mq[found].size() > 0) begin
        w = mq[found].pop_front();
        exp_q.push_back('{found, w[7:0], first});
        first = 1'b0;
      end
      ptr = (found + 1) % NREQ;
    end
    tx_auto = 1'b1; frame_cnt = 0; prev_en = 1'b0; prev_busy = 1'b0; pkt_baud = '0;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 3000) begin
      cfg_baud = 20'($urandom); cfg_check = 2'($urandom_range(0, 2));
      step(); n++;
      if (busy && !prev_busy) begin
        chk("rand_cfg_baud", tx_baud, cfg_baud);
        chk("rand_cfg_check", tx_check, cfg_check);
      end
      if (tx_en && !prev_en) begin
        chk("rand_expected_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          $display("rand byte: grant=%0d data=%02h (expect %0d/%02h)", grant_id, tx_dat, exp_q[0].g, exp_q[0].d);
          chk("rand_grant", grant_id, exp_q[0].g);
          chk("rand_dat", tx_dat, exp_q[0].d);
          if (exp_q[0].first) pkt_baud = tx_baud;
          else chk("rand_baud_fixed", tx_baud, pkt_baud);
          void'(exp_q.pop_front());
        end
      end
      prev_en = tx_en; prev_busy = busy;
    end
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_idle", busy, 0);
    tx_auto = 1'b0; tx_done = 1'b0;

`ifdef TX_TIMEOUT_EN
    // Stalled byte: tx_done never comes, abandon after 100 cycles.
    reset_dut();
    cfg_baud = 20'd9600; cfg_check = 2'd0;
    rq[0].push_back(9'h1E1); rq[1].push_back(9'h1E2);
    n = 0;
    while (tx_en !== 1'b1 && n < 40) begin step(); n++; end
    hi = 0;
    while (tx_en === 1'b1 && hi < 300) begin step(); hi++; end
    chk("tmo_len", hi, 100);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    serve(1, 8'hE2, 20'd9600, 2'd0);
`endif

    // Reset during SEND: everything back to reset values, nothing resumes.
    cfg_baud = 20'd9600; cfg_check = 2'd1;
    rq[3].push_back(9'h15A);
    n = 0;
    while (tx_en !== 1'b1 && n < 40) begin step(); n++; end
    chk("rstsend_active", tx_en, 1);
    RST = 1'b1;
    step();
    chk_reset_vals("rstsend");
    RST = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    pop_idx = -1;
    repeat (3) step();
    chk("rstsend_no_resume", {busy, tx_en}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
